// File: rtl/sine_capture.sv
// sine_capture: waits for an upward crossing of trig_level on the sample
// stream, records the next DEPTH samples into an internal RAM, then plays
// them back one beat at a time over a valid/ready port.
module sine_capture #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] trig_level,
  input  logic                  arm,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = {ADDR_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CAPTURE = 3'd2,
    S_FETCH   = 3'd3,
    S_READOUT = 3'd4
  } state_t;

  state_t                  state_r, state_nx;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0]   wr_ptr_r, wr_ptr_nx;
  logic [ADDR_WIDTH-1:0]   rd_ptr_r, rd_ptr_nx;
  logic [DATA_WIDTH-1:0]   prev_r, prev_nx;
  logic                    prev_ok_r, prev_ok_nx;
  logic [DATA_WIDTH-1:0]   rd_data_r;
  logic                    rd_valid_r, rd_last_r, busy_r, done_r, done_nx;
  logic                    wr_en_s, fetch_s, accept_s, trig_s;
  logic [ADDR_WIDTH-1:0]   wr_addr_s;

  // Next-state and datapath strobes; abort overrides every state.
  always_comb begin
    state_nx   = state_r;
    wr_ptr_nx  = wr_ptr_r;
    rd_ptr_nx  = rd_ptr_r;
    prev_nx    = prev_r;
    prev_ok_nx = prev_ok_r;
    done_nx    = 1'b0;
    wr_en_s    = 1'b0;
    wr_addr_s  = wr_ptr_r;
    fetch_s    = 1'b0;
    accept_s   = 1'b0;
    // A crossing needs a previous sample from this arming below the level.
    trig_s     = sample_valid && prev_ok_r &&
                 (prev_r < trig_level) && (sample_in >= trig_level);
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (arm) begin
            state_nx   = S_ARMED;
            prev_ok_nx = 1'b0;
          end else begin
            state_nx = S_IDLE;
          end
        end
        S_ARMED: begin
          if (sample_valid) begin
            prev_nx    = sample_in;
            prev_ok_nx = 1'b1;
            if (trig_s) begin
              wr_en_s   = 1'b1;
              wr_addr_s = PTR_ZERO;
              wr_ptr_nx = PTR_ONE;
              state_nx  = S_CAPTURE;
            end else begin
              state_nx = S_ARMED;
            end
          end else begin
            state_nx = S_ARMED;
          end
        end
        S_CAPTURE: begin
          if (sample_valid) begin
            wr_en_s   = 1'b1;
            wr_addr_s = wr_ptr_r;
            wr_ptr_nx = wr_ptr_r + PTR_ONE;
            // End is found by comparing, so the pointer wrap is never relied on.
            if (wr_ptr_r == PTR_LAST) begin
              rd_ptr_nx = PTR_ZERO;
              state_nx  = S_FETCH;
            end else begin
              state_nx = S_CAPTURE;
            end
          end else begin
            state_nx = S_CAPTURE;
          end
        end
        S_FETCH: begin
          fetch_s  = 1'b1;
          state_nx = S_READOUT;
        end
        S_READOUT: begin
          if (rd_valid_r && rd_ready) begin
            accept_s = 1'b1;
            if (rd_last_r) begin
              done_nx  = 1'b1;
              state_nx = S_IDLE;
            end else begin
              rd_ptr_nx = rd_ptr_r + PTR_ONE;
              state_nx  = S_FETCH;
            end
          end else begin
            state_nx = S_READOUT;
          end
        end
        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end
  end

  // Capture RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= sample_in;
    end
  end

  // State, pointers and registered readout outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      prev_r     <= {DATA_WIDTH{1'b0}};
      prev_ok_r  <= 1'b0;
      rd_data_r  <= {DATA_WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r   <= state_nx;
      wr_ptr_r  <= wr_ptr_nx;
      rd_ptr_r  <= rd_ptr_nx;
      prev_r    <= prev_nx;
      prev_ok_r <= prev_ok_nx;
      done_r    <= done_nx;
      busy_r    <= (state_nx != S_IDLE);
      if (abort) begin
        rd_valid_r <= 1'b0;
        rd_last_r  <= 1'b0;
      end else if (fetch_s) begin
        rd_data_r  <= mem_r[rd_ptr_r];
        rd_last_r  <= (rd_ptr_r == PTR_LAST);
        rd_valid_r <= 1'b1;
      end else if (accept_s) begin
        rd_valid_r <= 1'b0;
        rd_last_r  <= 1'b0;
      end else begin
        rd_valid_r <= rd_valid_r;
        rd_last_r  <= rd_last_r;
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign rd_last  = rd_last_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_sine_capture.sv
// Bench for sine_capture with DEPTH=8: directed scenarios plus random
// streams, checked against a queue-based model of the trigger rule.
module tb_sine_capture;

  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] sample_in = 8'd0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] trig_level = 8'd0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          rd_last;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] exp_buf [DEPTH];
  logic [DW-1:0] pre_q [$];

  sine_capture #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .trig_level(trig_level), .arm(arm), .abort(abort), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    sample_valid = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("armed_busy", {31'd0, busy}, 32'd1);
  endtask

  // Feed samples after arming; the model keeps every valid sample in a queue,
  // finds the first index t>=1 with q[t-1] < lvl <= q[t], and expects
  // q[t..t+DEPTH-1] to be the captured buffer.
  task automatic capture(input logic [DW-1:0] lvl, input int vmode, input bit ramp, output bit ok);
    logic [DW-1:0] q [$];
    logic [DW-1:0] v;
    bit val;
    int t;
    trig_level = lvl;
    do_arm();
    t = -1;
    ok = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      case (vmode)
        0:       val = 1'b1;
        1:       val = (cyc % 2 == 0);
        default: val = ($urandom_range(0, 1) == 1);
      endcase
      if (val && pre_q.size() > 0) v = pre_q.pop_front();
      else if (val && ramp)        v = DW'(q.size());
      else                         v = DW'($urandom_range(0, 255));
      sample_in    = v;
      sample_valid = val;
      tick();
      if (val) begin
        q.push_back(v);
        if (t < 0 && q.size() >= 2 && q[q.size()-2] < lvl && q[q.size()-1] >= lvl)
          t = q.size() - 1;
      end
      if (t >= 0 && q.size() >= t + DEPTH) begin
        ok = 1'b1;
        break;
      end
    end
    sample_valid = 1'b0;
    pre_q = {};
    if (ok) begin
      for (int i = 0; i < DEPTH; i++) exp_buf[i] = q[t + i];
      check("cap_busy", {31'd0, busy}, 32'd1);
      check("cap_no_valid_yet", {31'd0, rd_valid}, 32'd0);
    end else begin
      check("notrig_busy", {31'd0, busy}, 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
  endtask

  // Drain the buffer, checking order, rd_last placement, stability under
  // back-pressure and a single done pulse.
  task automatic readout(input int rmode, input bit arm_pulse);
    int k = 0;
    int dones = 0;
    int hold = 0;
    int tail = 0;
    bit pend = 1'b0;
    logic [DW-1:0] last_d = 8'd0;
    for (int c = 0; c < 300; c++) begin
      if (done) dones++;
      if (k == DEPTH) begin
        tail++;
        if (tail == 4) break;
      end
      if (pend) begin
        check("hold_valid", {31'd0, rd_valid}, 32'd1);
        check("hold_data", {24'd0, rd_data}, {24'd0, last_d});
      end
      pend = 1'b0;
      case (rmode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ($urandom_range(0, 1) == 1);
        default: begin
          if (k == 3 && rd_valid && hold < 5) begin
            rd_ready = 1'b0;
            hold++;
          end else begin
            rd_ready = 1'b1;
          end
        end
      endcase
      if (rd_valid && k < DEPTH) begin
        if (rd_ready) begin
          check("beat_data", {24'd0, rd_data}, {24'd0, exp_buf[k]});
          check("beat_last", {31'd0, rd_last}, {31'd0, (k == DEPTH - 1)});
          k++;
        end else begin
          pend   = 1'b1;
          last_d = rd_data;
        end
      end else if (rd_valid) begin
        check("extra_beat", {31'd0, rd_valid}, 32'd0);
      end
      arm = (arm_pulse && c == 3);
      tick();
    end
    arm = 1'b0;
    rd_ready = 1'b0;
    check("beats", k, DEPTH);
    check("done_pulses", dones, 1);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_valid", {31'd0, rd_valid}, 32'd0);
  endtask

  initial begin
    bit ok;
    bit seen_valid, seen_done;

    // Reset state.
    #12;
    check("rst_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_last", {31'd0, rd_last}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_data", {24'd0, rd_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Simultaneous arm and abort in IDLE: stays idle.
    arm = 1'b1;
    abort = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    check("arm_abort_idle", {31'd0, busy}, 32'd0);

    // Ramp 0,1,2.. with level 10: trigger on 10, buffer 10..17.
    capture(8'd10, 0, 1'b1, ok);
    check("t1_trig", {31'd0, ok}, 32'd1);
    readout(0, 1'b0);

    // First sample 200 must not trigger; crossing 6 -> 20 does.
    pre_q = {8'd200, 8'd5, 8'd6, 8'd20};
    capture(8'd10, 0, 1'b0, ok);
    check("t2_trig", {31'd0, ok}, 32'd1);
    readout(0, 1'b0);

    // Back-pressure: ready held low for 5 cycles on beat 3.
    capture(8'd50, 0, 1'b1, ok);
    check("t3_trig", {31'd0, ok}, 32'd1);
    readout(2, 1'b0);

    // Alternating sample_valid during capture; arm pulse during readout.
    capture(8'd30, 1, 1'b1, ok);
    check("t4_trig", {31'd0, ok}, 32'd1);
    readout(1, 1'b1);

    // Abort in CAPTURE: idle next edge, no readout, no done.
    trig_level = 8'd10;
    do_arm();
    for (int i = 0; i < 13; i++) begin
      sample_in = i[7:0];
      sample_valid = 1'b1;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    seen_valid = 1'b0;
    seen_done = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sample_in = DW'($urandom_range(0, 255));
      sample_valid = ($urandom_range(0, 1) == 1);
      tick();
      seen_valid |= rd_valid;
      seen_done |= done;
    end
    sample_valid = 1'b0;
    rd_ready = 1'b0;
    check("abort_no_valid", {31'd0, seen_valid}, 32'd0);
    check("abort_no_done", {31'd0, seen_done}, 32'd0);
    check("abort_still_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-readout, then a clean capture.
    capture(8'd100, 2, 1'b0, ok);
    check("t6_trig", {31'd0, ok}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (rd_valid) break;
      tick();
    end
    check("t6_valid_before_rst", {31'd0, rd_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, rd_valid}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_last", {31'd0, rd_last}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    capture(8'd77, 0, 1'b0, ok);
    if (ok) readout(1, 1'b0);

    // Random streams, levels, valid and ready patterns.
    for (int n = 0; n < 8; n++) begin
      capture(DW'($urandom_range(20, 235)), 2, 1'b0, ok);
      if (ok) readout(1, ($urandom_range(0, 1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
